// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the multi-channel switch debouncer.
// Optional auto-repeat is built only when DEBOUNCE_REPEAT_EN is defined.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO,
        PEND_HI,
        STABLE_HI,
        PEND_LO
    } chan_state_t;

    // Bits needed for a counter holding 0..n-1, never narrower than one bit.
    function automatic int width_for(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: 2-flop synchroniser, tick-driven stability FSM, edge pulses.
// Auto-repeat output is built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE        = 8,
    parameter int RESET_LEVEL   = 0,
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10
) (
    input  logic Clk,
    input  logic reset,
    input  logic sample_tick,
    input  logic switch_in,
    output logic switch_out,
    output logic rise,
    output logic fall,
    output logic repeat_out
);

    localparam int CW = width_for(STABLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);
    localparam logic RST_BIT = (RESET_LEVEL != 0);
    localparam chan_state_t RST_STATE = RST_BIT ? STABLE_HI : STABLE_LO;

    logic sync_a, sync_b;
    chan_state_t state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic commit_hi, commit_lo;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            sync_a <= RST_BIT;
            sync_b <= RST_BIT;
        end else begin
            sync_a <= switch_in;
            sync_b <= sync_a;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit_hi  = 1'b0;
        commit_lo  = 1'b0;
        if (sample_tick) begin
            case (state)
                STABLE_LO: if (sync_b) begin
                    state_next = PEND_HI;
                    cnt_next   = CW'(1);
                end
                PEND_HI: begin
                    if (!sync_b) begin
                        state_next = STABLE_LO;
                        cnt_next   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next = STABLE_HI;
                        cnt_next   = '0;
                        commit_hi  = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                STABLE_HI: if (!sync_b) begin
                    state_next = PEND_LO;
                    cnt_next   = CW'(1);
                end
                PEND_LO: begin
                    if (sync_b) begin
                        state_next = STABLE_HI;
                        cnt_next   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next = STABLE_LO;
                        cnt_next   = '0;
                        commit_lo  = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = RST_STATE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Level and edge pulses are registered together, so a pulse coincides
    // with the first cycle the new level is visible.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state      <= RST_STATE;
            cnt        <= '0;
            switch_out <= RST_BIT;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            rise  <= commit_hi;
            fall  <= commit_lo;
            if (commit_hi)
                switch_out <= 1'b1;
            else if (commit_lo)
                switch_out <= 1'b0;
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int RW = width_for(REPEAT_DELAY + REPEAT_PERIOD + 1);

    logic [RW-1:0] rep_cnt, rep_inc;
    logic rep_hit_first, rep_hit_next;

    assign rep_inc       = rep_cnt + 1'b1;
    assign rep_hit_first = (rep_inc == RW'(REPEAT_DELAY));
    assign rep_hit_next  = (rep_inc == RW'(REPEAT_DELAY + REPEAT_PERIOD));

    // The commit tick leaves the counter at 0; after the first pulse the
    // counter reloads to REPEAT_DELAY so later pulses are REPEAT_PERIOD apart.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            rep_cnt    <= '0;
            repeat_out <= 1'b0;
        end else begin
            repeat_out <= 1'b0;
            if (state == STABLE_HI && state_next == STABLE_HI) begin
                if (sample_tick) begin
                    if (rep_hit_next) begin
                        rep_cnt    <= RW'(REPEAT_DELAY);
                        repeat_out <= 1'b1;
                    end else begin
                        rep_cnt    <= rep_inc;
                        repeat_out <= rep_hit_first;
                    end
                end
            end else begin
                rep_cnt <= '0;
            end
        end
    end
`else
    assign repeat_out = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer with a shared sample-tick prescaler.
// Define DEBOUNCE_REPEAT_EN to build the per-channel auto-repeat pulses.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CH            = 4,
    parameter int DIV           = 100000,
    parameter int STABLE        = 8,
    parameter int RESET_LEVEL   = 0,
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic [CH-1:0] switch_in,
    output logic [CH-1:0] switch_out,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] repeat_out,
    output logic          sample_tick
);

    localparam int PW = width_for(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] pre_cnt, pre_next;

    assign pre_next = (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;

    // Tick is registered from the next count so it is high exactly while
    // the prescaler holds DIV-1, and low during reset.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            pre_cnt     <= '0;
            sample_tick <= 1'b0;
        end else begin
            pre_cnt     <= pre_next;
            sample_tick <= (pre_next == PRE_LAST);
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
        debounce_chan #(
            .STABLE       (STABLE),
            .RESET_LEVEL  (RESET_LEVEL),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_chan (
            .Clk        (Clk),
            .reset      (reset),
            .sample_tick(sample_tick),
            .switch_in  (switch_in[i]),
            .switch_out (switch_out[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .repeat_out (repeat_out[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank; a sample-history reference model predicts every output.
// Repeat expectations follow DEBOUNCE_REPEAT_EN.
module tb_debounce_bank;

    localparam int CH = 4, DIV = 4, STABLE = 3, RESET_LEVEL = 0;
    localparam int REPEAT_DELAY = 5, REPEAT_PERIOD = 2;
`ifdef DEBOUNCE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] so;
        logic [3:0] ri;
        logic [3:0] fa;
        logic [3:0] rp;
        logic       tk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] switch_in = 4'hF;
    logic [3:0] switch_out, rise, fall, repeat_out;
    logic       sample_tick;
    logic [16:0] obs;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [3:0] m_s1, m_s2, m_out, s_old;
    logic [2:0] m_hist[4];
    int         m_held[4];
    int         m_pre;
    logic       m_tick, t_old;
    exp_t       m_e;

    debounce_bank #(
        .CH(CH), .DIV(DIV), .STABLE(STABLE), .RESET_LEVEL(RESET_LEVEL),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) dut (
        .Clk        (clk),
        .reset      (rst_n),
        .switch_in  (switch_in),
        .switch_out (switch_out),
        .rise       (rise),
        .fall       (fall),
        .repeat_out (repeat_out),
        .sample_tick(sample_tick)
    );

    assign obs = {switch_out, rise, fall, repeat_out, sample_tick};

    always #5 clk = ~clk;

    always @(negedge rst_n) sb_q.delete();

    // Reference model: a level commits once the last STABLE tick samples all
    // disagree with it; repeat timing counts consecutive high samples.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 = 4'h0; m_s2 = 4'h0; m_out = 4'h0; m_pre = 0; m_tick = 1'b0;
            for (int c = 0; c < 4; c++) begin
                m_hist[c] = 3'b000;
                m_held[c] = 0;
            end
            m_e = '0;
        end else begin
            s_old = m_s2;
            t_old = m_tick;
            m_s2 = m_s1;
            m_s1 = switch_in;
            m_pre = (m_pre + 1) % DIV;
            m_tick = (m_pre == DIV - 1);
            m_e.ri = 4'h0; m_e.fa = 4'h0; m_e.rp = 4'h0;
            if (t_old) begin
                for (int c = 0; c < 4; c++) begin
                    m_hist[c] = {m_hist[c][1:0], s_old[c]};
                    if (m_hist[c] == {3{~m_out[c]}}) begin
                        m_out[c] = ~m_out[c];
                        if (m_out[c]) m_e.ri[c] = 1'b1;
                        else          m_e.fa[c] = 1'b1;
                        m_held[c] = 0;
                    end else if (m_out[c] && m_hist[c][1:0] == 2'b11) begin
                        m_held[c]++;
                        if (REP_EN && m_held[c] >= REPEAT_DELAY &&
                            (m_held[c] - REPEAT_DELAY) % REPEAT_PERIOD == 0)
                            m_e.rp[c] = 1'b1;
                    end else begin
                        m_held[c] = 0;
                    end
                end
            end
            m_e.so = m_out;
            m_e.tk = m_tick;
        end
        sb_q.push_back(m_e);
    end

    task automatic pop_cycle(output exp_t e, output bit got);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            got = 1'b0;
            e = '0;
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL scoreboard_empty t=%0t: no expected entry", $time);
        end else begin
            e = sb_q.pop_front();
            got = 1'b1;
        end
    endtask

    task automatic test_reset();
        exp_t e; bit got;
        rst_n = 1'b0;
        switch_in = 4'hF;
        for (int c = 0; c < 3; c++) begin
            pop_cycle(e, got);
            n_cmp++;
            if (obs !== 17'h0) begin
                n_bad++;
                $display("[TB] FAIL reset_values got=%h required=%h", obs, 17'h0);
            end
            if (got) begin
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("[TB] FAIL reset_sb got=%h required=%h", obs, e);
                end
            end
        end
        switch_in = 4'h0;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            pop_cycle(e, got);
            if (got) begin
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("[TB] FAIL post_reset got=%h required=%h", obs, e);
                end
            end
        end
    endtask

    task automatic test_ch0_rise();
        exp_t e; bit got;
        int ticks = 0, rises = 0, lat = -1;
        switch_in[0] = 1'b1;
        for (int c = 0; c < 200 && ticks < 20; c++) begin
            pop_cycle(e, got);
            if (rise[0]) rises++;
            if (lat < 0 && switch_out[0]) lat = c + 1;
            if (got) begin
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("[TB] FAIL ch0_rise c=%0d got=%h required=%h", c, obs, e);
                end
                if (e.tk) ticks++;
            end
        end
        n_cmp++;
        if (rises != 1) begin
            n_bad++;
            $display("[TB] FAIL ch0_rise_width pulses=%0d required=1", rises);
        end
        n_cmp++;
        if (lat < 2 + (STABLE - 1) * DIV + 1 || lat > 2 + STABLE * DIV) begin
            n_bad++;
            $display("[TB] FAIL ch0_rise_latency cycles=%0d required=%0d..%0d",
                     lat, 2 + (STABLE - 1) * DIV + 1, 2 + STABLE * DIV);
        end
    endtask

    task automatic test_ch1_bounce();
        exp_t e; bit got;
        int ticks = 0, edges = 0;
        for (int c = 0; c < 200 && ticks < 16; c++) begin
            pop_cycle(e, got);
            if (rise[1] || fall[1]) edges++;
            if (got) begin
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("[TB] FAIL ch1_bounce c=%0d got=%h required=%h", c, obs, e);
                end
                if (e.tk) begin
                    ticks++;
                    switch_in[1] = (ticks < 10) ? ~switch_in[1] : 1'b0;
                end
            end
        end
        n_cmp++;
        if (edges != 0 || switch_out[1] !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL ch1_no_commit edges=%0d level=%b required 0/0", edges, switch_out[1]);
        end
    endtask

    task automatic test_ch0_fall();
        exp_t e; bit got;
        int ticks = 0, falls = 0;
        switch_in[0] = 1'b0;
        for (int c = 0; c < 200 && ticks < 8; c++) begin
            pop_cycle(e, got);
            if (fall[0]) falls++;
            if (got) begin
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("[TB] FAIL ch0_fall c=%0d got=%h required=%h", c, obs, e);
                end
                if (e.tk) ticks++;
            end
        end
        n_cmp++;
        if (falls != 1 || switch_out[0] !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL ch0_fall_pulse pulses=%0d level=%b required 1/0", falls, switch_out[0]);
        end
    endtask

    task automatic test_reset_mid_pend();
        exp_t e; bit got;
        bit   armed = 1'b0;
        int   ticks = 0, rises = 0;
        switch_in[2] = 1'b1;
        for (int c = 0; c < 60 && !armed; c++) begin
            pop_cycle(e, got);
            if (rise[2]) rises++;
            if (got) begin
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("[TB] FAIL mid_pend_arm c=%0d got=%h required=%h", c, obs, e);
                end
            end
            if (m_hist[2] == 3'b011 && m_out[2] == 1'b0) armed = 1'b1;
        end
        if (!armed) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL mid_pend_timeout got=0 required=1");
        end
        rst_n = 1'b0;
        switch_in[2] = 1'b0;
        pop_cycle(e, got);
        if (got) begin
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("[TB] FAIL mid_pend_reset got=%h required=%h", obs, e);
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 100 && ticks < 8; c++) begin
            pop_cycle(e, got);
            if (rise[2]) rises++;
            if (got) begin
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("[TB] FAIL mid_pend_after c=%0d got=%h required=%h", c, obs, e);
                end
                if (e.tk) ticks++;
            end
        end
        n_cmp++;
        if (rises != 0 || switch_out[2] !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL mid_pend_discard rises=%0d level=%b required 0/0", rises, switch_out[2]);
        end
    endtask

    task automatic test_simultaneous();
        exp_t e; bit got;
        int both_rise = 0, both_fall = 0;
        for (int phase = 0; phase < 2; phase++) begin
            int ticks = 0;
            switch_in[1:0] = (phase == 0) ? 2'b11 : 2'b00;
            for (int c = 0; c < 100 && ticks < 6; c++) begin
                pop_cycle(e, got);
                if (rise[1:0] == 2'b11) both_rise++;
                if (fall[1:0] == 2'b11) both_fall++;
                if (got) begin
                    n_cmp++;
                    if (obs !== e) begin
                        n_bad++;
                        $display("[TB] FAIL simultaneous c=%0d got=%h required=%h", c, obs, e);
                    end
                    if (e.tk) ticks++;
                end
            end
        end
        n_cmp++;
        if (both_rise != 1 || both_fall != 1) begin
            n_bad++;
            $display("[TB] FAIL simultaneous_pulses rise=%0d fall=%0d required 1/1", both_rise, both_fall);
        end
    endtask

    task automatic test_repeat();
        exp_t e; bit got;
        bit committed = 1'b0, done = 1'b0;
        int ticks = 0, pulses = 0;
        int want = REP_EN ? 4 : 0;
        switch_in[3] = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            pop_cycle(e, got);
            if (got) begin
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("[TB] FAIL repeat c=%0d got=%h required=%h", c, obs, e);
                end
                if (committed) begin
                    if (repeat_out[3]) pulses++;
                    if (ticks == 12) done = 1'b1;
                    else if (e.tk) ticks++;
                end else if (e.so[3]) begin
                    committed = 1'b1;
                end
            end
        end
        n_cmp++;
        if (!done || pulses != want) begin
            n_bad++;
            $display("[TB] FAIL repeat_count pulses=%0d done=%b required %0d/1", pulses, done, want);
        end
        switch_in[3] = 1'b0;
        ticks = 0;
        for (int c = 0; c < 100 && ticks < 6; c++) begin
            pop_cycle(e, got);
            if (got) begin
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("[TB] FAIL repeat_release c=%0d got=%h required=%h", c, obs, e);
                end
                if (e.tk) ticks++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_ch0_rise();
        test_ch1_bounce();
        test_ch0_fall();
        test_reset_mid_pend();
        test_simultaneous();
        test_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog t=%0t required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
